program_sequencer: RTL and testbench

Instruction-issuing initiator for the simple processor's `Run`/`DIN`/`Done` handshake. It holds a small program RAM of 9-bit words in `IIIXXXYYY` format. It feeds instructions, and the immediate word for `mvi`, onto `DIN`, pulses `Run`, and waits for `Done` before issuing the next instruction. It sits beside the processor top in the system and testbench, driving the processor's `DIN` and `Run` inputs and observing its `Done` output.

---
 rtl/program_sequencer.sv | 173 +++++++++++++++++
 tb/tb_program_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: issues instructions from a small program RAM to the
// simple processor over its Run/DIN/Done handshake. Each mvi is followed by
// its immediate word. Execution stops on a 3'b111 opcode, on an mvi that has
// no room for its immediate, or when the program counter runs off the end.
// Optional watchdog: define SEQ_WATCHDOG_EN to flag an Error when Done does
// not arrive within TIMEOUT cycles of an issued instruction.
module program_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Done,
    output logic [8:0]        DIN,
    output logic              Run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [8:0]        prog_data,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       instr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_IMM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [2:0]        state;
    logic [8:0]        mem [DEPTH];
    logic              wrapped;
    logic              timeout_hit;
    logic              start_ok;
    logic              issue_req;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_wrapped;
    logic [8:0]        issue_word;
    logic              issue_halt;
    logic              prog_open;

    // The program RAM only accepts writes while no program is running
    assign prog_open = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);

    // Program RAM write port; contents deliberately survive reset
    always_ff @(posedge Clock) begin
        if (prog_we && prog_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Decide whether this edge issues a new word and whether that word ends the program
    always_comb begin
        start_ok      = Start && prog_open;
        issue_req     = start_ok || (((state == S_IMM) || (state == S_WAIT)) && Done);
        issue_addr    = start_ok ? '0 : PC;
        issue_wrapped = start_ok ? 1'b0 : wrapped;
        issue_word    = mem[issue_addr];
        issue_halt    = issue_wrapped
                     || (issue_word[8:6] == OP_HALT)
                     || ((issue_word[8:6] == OP_MVI) && (issue_addr == LAST_ADDR));
    end

    // Main sequencer: every output is a register loaded on the edge that enters its state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            DIN         <= '0;
            Run         <= 1'b0;
            Busy        <= 1'b0;
            Halted      <= 1'b0;
            PC          <= '0;
            instr_count <= '0;
            wrapped     <= 1'b0;
        end else begin
            Run <= 1'b0;
            if (issue_req) begin
                if (issue_halt) begin
                    state       <= S_HALT;
                    DIN         <= '0;
                    Busy        <= 1'b0;
                    Halted      <= 1'b1;
                    PC          <= issue_addr;
                    wrapped     <= issue_wrapped;
                    instr_count <= start_ok ? 16'd0 : instr_count;
                end else begin
                    state   <= S_ISSUE;
                    DIN     <= issue_word;
                    Run     <= 1'b1;
                    Busy    <= 1'b1;
                    Halted  <= 1'b0;
                    PC      <= issue_addr + 1'b1;
                    wrapped <= (issue_addr == LAST_ADDR);
                    if (start_ok) begin
                        instr_count <= 16'd1;
                    end else if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                end
            end else if (timeout_hit) begin
                state <= S_ERR;
                DIN   <= '0;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    S_ISSUE: begin
                        if (DIN[8:6] == OP_MVI) begin
                            state   <= S_IMM;
                            DIN     <= mem[PC];
                            PC      <= PC + 1'b1;
                            wrapped <= (PC == LAST_ADDR);
                        end else begin
                            state <= S_WAIT;
                            DIN   <= '0;
                        end
                    end
                    S_IMM: begin
                        state <= S_WAIT;
                        DIN   <= '0;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        error_q;

    assign timeout_hit = ((state == S_IMM) || (state == S_WAIT)) && !Done
                      && (wd_cnt == 16'(TIMEOUT - 1));
    assign Error = error_q;

    // Watchdog counter: restarts on each Run strobe, counts cycles spent waiting for Done
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wd_cnt <= '0;
        end else if (Run) begin
            wd_cnt <= '0;
        end else if (((state == S_IMM) || (state == S_WAIT)) && !Done) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // Error flag: raised on expiry, cleared only by Reset or a new Start
    always_ff @(posedge Clock) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else if (start_ok) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Error       = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: table-driven cycle checks, hand-written corner
// sequences and randomized programs compared against a program-level model.
module tb_program_sequencer;

    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;

    logic        Clock = 1'b0;
    logic        Reset, Start, Done, prog_we;
    logic [3:0]  prog_addr;
    logic [8:0]  prog_data;
    logic [8:0]  DIN;
    logic        Run, Busy, Halted, Error;
    logic [3:0]  PC;
    logic [15:0] instr_count;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        int          prog;
        logic        start;
        logic        done;
        logic        run;
        logic [8:0]  din;
        logic        busy;
        logic        halted;
        logic [3:0]  pc;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [8:0] word;
        bit         has_imm;
        logic [8:0] imm;
        int         addr;
    } issue_t;

    logic [8:0] shadow [DEPTH];
    logic [8:0] progs  [5][DEPTH];
    vec_t       vecs[$];
    issue_t     expq[$];
    int         exp_count;
    int         exp_pc;

    program_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Done(Done),
        .DIN(DIN), .Run(Run),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .Busy(Busy), .Halted(Halted), .Error(Error), .PC(PC),
        .instr_count(instr_count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("[TB] FAIL global time limit: got no finish, expected finish");
        $fatal(1, "[TB] time limit");
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic done);
        Start = start;
        Done  = done;
        tick();
    endtask

    task automatic loadProgram();
        Start = 1'b0;
        Done  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = shadow[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic selectProgram(input int idx);
        for (int i = 0; i < DEPTH; i++) shadow[i] = progs[idx][i];
        loadProgram();
    endtask

    // Walks the program as the processor would see it: words, immediates, final PC
    task automatic buildModel();
        int p;
        logic [8:0] w;
        issue_t e;
        expq.delete();
        exp_count = 0;
        p = 0;
        while (p < DEPTH) begin
            w = shadow[p];
            if (w[8:6] == 3'b111) break;
            if (w[8:6] == 3'b001 && p == DEPTH - 1) break;
            e.word    = w;
            e.addr    = p;
            e.has_imm = (w[8:6] == 3'b001);
            e.imm     = 9'd0;
            if (e.has_imm) e.imm = shadow[p + 1];
            expq.push_back(e);
            exp_count++;
            p += e.has_imm ? 2 : 1;
        end
        exp_pc = p % DEPTH;
    endtask

    task automatic execProgram(input int max_delay, input bit poke,
                               input logic [3:0] poke_addr, input logic [8:0] poke_data);
        int d;
        issue_t e;
        buildModel();
        applyStimulus(1'b1, 1'b0);
        Start = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
            e = expq[i];
            checkOutput("run strobe", 32'(Run), 32'd1);
            checkOutput("issued word", 32'(DIN), 32'(e.word));
            checkOutput("pc at issue", 32'(PC), 32'((e.addr + 1) % DEPTH));
            checkOutput("count at issue", 32'(instr_count), 32'(i + 1));
            if (poke && i == 0) begin
                prog_we   = 1'b1;
                prog_addr = poke_addr;
                prog_data = poke_data;
            end
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            prog_we = 1'b0;
            checkOutput(e.has_imm ? "immediate word" : "wait din", 32'(DIN),
                        e.has_imm ? 32'(e.imm) : 32'd0);
            checkOutput("run low after strobe", 32'(Run), 32'd0);
            checkOutput("busy while executing", 32'(Busy), 32'd1);
            d = $urandom_range(0, max_delay);
            for (int k = 0; k < d; k++) begin
                applyStimulus(1'b0, 1'b0);
                checkOutput("wait din", 32'(DIN), 32'd0);
                checkOutput("wait run", 32'(Run), 32'd0);
            end
            applyStimulus(1'b0, 1'b1);
            Done = 1'b0;
        end
        checkOutput("halted at end", 32'(Halted), 32'd1);
        checkOutput("busy at end", 32'(Busy), 32'd0);
        checkOutput("run at end", 32'(Run), 32'd0);
        checkOutput("final pc", 32'(PC), 32'(exp_pc));
        checkOutput("final count", 32'(instr_count), 32'(exp_count));
        checkOutput("error at end", 32'(Error), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " DIN"}, 32'(DIN), 32'd0);
        checkOutput({tag, " Run"}, 32'(Run), 32'd0);
        checkOutput({tag, " Busy"}, 32'(Busy), 32'd0);
        checkOutput({tag, " Halted"}, 32'(Halted), 32'd0);
        checkOutput({tag, " Error"}, 32'(Error), 32'd0);
        checkOutput({tag, " PC"}, 32'(PC), 32'd0);
        checkOutput({tag, " count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Done = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        for (int p = 0; p < 5; p++)
            for (int a = 0; a < DEPTH; a++) progs[p][a] = 9'o700;
        progs[0][0] = 9'o100; progs[0][1] = 9'd5;
        progs[1][0] = 9'o201;
        progs[2][0] = 9'o201; progs[2][1] = 9'o202;
        progs[3][0] = 9'o100; progs[3][1] = 9'd7; progs[3][2] = 9'o201;

        // prog, start, done | run, din, busy, halted, pc, count
        vecs.push_back('{0, 1, 0, 1, 9'o100, 1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd5,  1, 0, 4'd2, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd2, 16'd1});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  0, 1, 4'd2, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  0, 1, 4'd2, 16'd1});
        vecs.push_back('{1, 1, 0, 1, 9'o201, 1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  0, 1, 4'd1, 16'd1});
        vecs.push_back('{2, 1, 0, 1, 9'o201, 1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 1, 1, 9'o202, 1, 0, 4'd2, 16'd2});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  1, 0, 4'd2, 16'd2});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  0, 1, 4'd2, 16'd2});
        vecs.push_back('{3, 1, 0, 1, 9'o100, 1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 1, 0, 9'd7,  1, 0, 4'd2, 16'd1});
        vecs.push_back('{-1, 0, 1, 1, 9'o201, 1, 0, 4'd3, 16'd2});
        vecs.push_back('{-1, 0, 0, 0, 9'd0,  1, 0, 4'd3, 16'd2});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  0, 1, 4'd3, 16'd2});
        vecs.push_back('{4, 1, 0, 0, 9'd0,   0, 1, 4'd0, 16'd0});
        vecs.push_back('{1, 1, 0, 1, 9'o201, 1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 1, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 1, 0, 0, 9'd0,  1, 0, 4'd1, 16'd1});
        vecs.push_back('{-1, 0, 1, 0, 9'd0,  0, 1, 4'd1, 16'd1});

        tick();
        tick();
        Reset = 1'b0;
        checkAllZero("reset");

        foreach (vecs[i]) begin
            if (vecs[i].prog >= 0) selectProgram(vecs[i].prog);
            applyStimulus(vecs[i].start, vecs[i].done);
            checkOutput($sformatf("vec%0d Run", i), 32'(Run), 32'(vecs[i].run));
            checkOutput($sformatf("vec%0d DIN", i), 32'(DIN), 32'(vecs[i].din));
            checkOutput($sformatf("vec%0d Busy", i), 32'(Busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d Halted", i), 32'(Halted), 32'(vecs[i].halted));
            checkOutput($sformatf("vec%0d PC", i), 32'(PC), 32'(vecs[i].pc));
            checkOutput($sformatf("vec%0d count", i), 32'(instr_count), 32'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d Error", i), 32'(Error), 32'd0);
        end
        Start = 1'b0;
        Done  = 1'b0;

        // Sixteen mv words: PC wraps and ends the run; a write while busy must be dropped
        for (int i = 0; i < DEPTH; i++) shadow[i] = {3'b000, 6'(i)};
        loadProgram();
        execProgram(3, 1'b1, 4'd15, 9'o700);

        // mvi in the last slot has no immediate and ends the program
        for (int i = 0; i < DEPTH - 1; i++) shadow[i] = {3'b000, 6'(i + 1)};
        shadow[DEPTH - 1] = 9'o100;
        loadProgram();
        execProgram(2, 1'b0, 4'd0, 9'd0);

        // mvi one before the end: its immediate (a halt pattern) is data, then PC wraps
        for (int i = 0; i < DEPTH - 2; i++) shadow[i] = {3'b010, 6'(i)};
        shadow[DEPTH - 2] = 9'o100;
        shadow[DEPTH - 1] = 9'o700;
        loadProgram();
        execProgram(2, 1'b0, 4'd0, 9'd0);

        // Long wait for Done
        selectProgram(1);
        applyStimulus(1'b1, 1'b0);
        Start = 1'b0;
        checkOutput("long wait run", 32'(Run), 32'd1);
        for (int k = 0; k < TIMEOUT; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("long wait busy before limit", 32'(Busy), 32'd1);
        checkOutput("long wait error before limit", 32'(Error), 32'd0);
        applyStimulus(1'b0, 1'b0);
`ifdef SEQ_WATCHDOG_EN
        checkOutput("watchdog error", 32'(Error), 32'd1);
        checkOutput("watchdog busy", 32'(Busy), 32'd0);
        checkOutput("watchdog run", 32'(Run), 32'd0);
        checkOutput("watchdog din", 32'(DIN), 32'd0);
        applyStimulus(1'b1, 1'b0);
        Start = 1'b0;
        checkOutput("restart run", 32'(Run), 32'd1);
        checkOutput("restart din", 32'(DIN), 32'o201);
        checkOutput("restart pc", 32'(PC), 32'd1);
        checkOutput("restart error cleared", 32'(Error), 32'd0);
        applyStimulus(1'b0, 1'b0);
`else
        checkOutput("no watchdog error", 32'(Error), 32'd0);
        checkOutput("no watchdog busy", 32'(Busy), 32'd1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("still waiting", 32'(Busy), 32'd1);
`endif
        applyStimulus(1'b0, 1'b1);
        Done = 1'b0;
        checkOutput("after long wait halted", 32'(Halted), 32'd1);
        checkOutput("after long wait count", 32'(instr_count), 32'd1);

        // Reset mid-WAIT, then Reset colliding with Start, then RAM retention
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        Reset = 1'b0;
        checkAllZero("mid-wait reset");
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        Reset = 1'b0;
        Start = 1'b0;
        checkAllZero("reset with start");
        applyStimulus(1'b1, 1'b0);
        Start = 1'b0;
        checkOutput("retained run", 32'(Run), 32'd1);
        checkOutput("retained word", 32'(DIN), 32'o201);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        Done = 1'b0;
        checkOutput("retained halted", 32'(Halted), 32'd1);

        // Randomized programs against the program-level model
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = 9'($urandom);
            loadProgram();
            execProgram(4, 1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
